// File: rtl/tag_pkg.sv
// Shared definitions for the tag radio blocks: sequencer state encoding and
// the IQ / IF-code width defaults used by the RX path, scan serializer and GPIO.
package tag_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_LOC_SYNC = 2'd1,
    ST_HOP_SYNC = 2'd2,
    ST_HOP_RX   = 2'd3
  } state_t;

  localparam int SYNC_AMP_DEF   = 28672;
  localparam int DATA_WIDTH_DEF = 16;
  localparam int CODE_WIDTH_DEF = 32;

endpackage

// File: rtl/hop_code_table.sv
// Hop IF code storage: one write port, one synchronous read port, no reset on
// the array so it maps onto block RAM.
module hop_code_table
  import tag_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = 6,
  parameter int DW    = CODE_WIDTH_DEF
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/tag_rx_hop_seq.sv
// Tag receive sequencer: injects a localisation preamble into the RX IQ stream,
// then walks the hop table with a settle window and a gated receive interval.
module tag_rx_hop_seq
  import tag_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int CODE_WIDTH = CODE_WIDTH_DEF,
  parameter int MAX_HOPS   = 64,
  parameter int IDX_WIDTH  = 6,
  parameter int CNT_WIDTH  = 24,
  parameter int SYNC_AMP   = SYNC_AMP_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [IDX_WIDTH:0]           cfg_nhops,
  input  logic [CNT_WIDTH-1:0]         cfg_nsync_loc,
  input  logic [CNT_WIDTH-1:0]         cfg_nsync_hop,
  input  logic [CNT_WIDTH-1:0]         cfg_hop_settle,
  input  logic [CNT_WIDTH-1:0]         cfg_nsig,
  input  logic                         cfg_continuous,
  input  logic                         tbl_we,
  input  logic [IDX_WIDTH-1:0]         tbl_addr,
  input  logic [CODE_WIDTH-1:0]        tbl_wdata,
  input  logic                         trigger,
  input  logic                         abort,
  input  logic signed [DATA_WIDTH-1:0] irx_in,
  input  logic signed [DATA_WIDTH-1:0] qrx_in,
  output logic signed [DATA_WIDTH-1:0] irx_out,
  output logic signed [DATA_WIDTH-1:0] qrx_out,
  output logic                         rx_valid,
  output logic                         rx_gate,
  output logic                         hop_rst,
  output logic [IDX_WIDTH-1:0]         hop_idx,
  output logic [CODE_WIDTH-1:0]        hop_code,
  output logic [1:0]                   state,
  output logic                         done,
  output logic                         err_cfg
);

  localparam logic signed [DATA_WIDTH-1:0] AMP_P = DATA_WIDTH'(SYNC_AMP);
  localparam logic signed [DATA_WIDTH-1:0] AMP_N = -AMP_P;
  localparam logic [IDX_WIDTH:0]   NHOPS_MAX = (IDX_WIDTH+1)'(MAX_HOPS);
  localparam logic [IDX_WIDTH:0]   NHOPS_ONE = (IDX_WIDTH+1)'(1);
  localparam logic [IDX_WIDTH-1:0] IDX_ONE   = IDX_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

  state_t               state_q, state_n;
  logic [CNT_WIDTH-1:0] k_q, k_n;
  logic [IDX_WIDTH-1:0] idx_q, idx_n;
  logic                 done_n, err_set, cfg_ok, latch;
  logic                 valid_n, neg_n, gate_n, hrst_n;
  logic [CNT_WIDTH-1:0] l_use;
  logic [CODE_WIDTH-1:0] tbl_rdata;

  logic [IDX_WIDTH:0]   sh_nhops;
  logic [CNT_WIDTH-1:0] sh_nsync_loc, sh_nsync_hop, sh_hop_settle, sh_nsig;
  logic                 sh_continuous;

  hop_code_table #(
    .DEPTH(MAX_HOPS),
    .AW   (IDX_WIDTH),
    .DW   (CODE_WIDTH)
  ) u_table (
    .clk  (clk),
    .we   (tbl_we),
    .waddr(tbl_addr),
    .wdata(tbl_wdata),
    .raddr(idx_n),
    .rdata(tbl_rdata)
  );

  assign cfg_ok = (cfg_nhops != '0) && (cfg_nhops <= NHOPS_MAX)
               && (cfg_nsync_loc >= CNT_WIDTH'(4))
               && (cfg_hop_settle >= CNT_WIDTH'(2))
               && (cfg_hop_settle < cfg_nsync_hop)
               && (cfg_nsig != '0);
  assign latch  = (state_q == ST_IDLE) && trigger && !abort && cfg_ok;

  always_comb begin
    state_n = state_q;
    k_n     = k_q + CNT_ONE;
    idx_n   = idx_q;
    done_n  = 1'b0;
    err_set = 1'b0;
    if (abort) begin
      state_n = ST_IDLE;
      k_n     = '0;
      idx_n   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          k_n = '0;
          if (trigger) begin
            if (cfg_ok) begin
              state_n = ST_LOC_SYNC;
              idx_n   = '0;
            end else begin
              err_set = 1'b1;
            end
          end
        end
        ST_LOC_SYNC: begin
          if (k_q == sh_nsync_loc - CNT_ONE) begin
            state_n = ST_HOP_SYNC;
            k_n     = '0;
          end
        end
        ST_HOP_SYNC: begin
          if (k_q == sh_nsync_hop - CNT_ONE) begin
            state_n = ST_HOP_RX;
            k_n     = '0;
          end
        end
        ST_HOP_RX: begin
          if (k_q == sh_nsig - CNT_ONE) begin
            k_n = '0;
            if ({1'b0, idx_q} < sh_nhops - NHOPS_ONE) begin
              idx_n   = idx_q + IDX_ONE;
              state_n = ST_HOP_SYNC;
            end else begin
              done_n  = 1'b1;
              idx_n   = '0;
              state_n = sh_continuous ? ST_LOC_SYNC : ST_IDLE;
            end
          end
        end
        default: begin
          state_n = ST_IDLE;
          k_n     = '0;
        end
      endcase
    end
  end

  // Flags are decoded from the next state/count so they line up with state_q
  // and with the sample registered on the same edge.
  always_comb begin
    l_use   = (state_q == ST_IDLE) ? cfg_nsync_loc : sh_nsync_loc;
    valid_n = (state_n == ST_LOC_SYNC) && (k_n >= (l_use >> 2));
    neg_n   = (k_n < (l_use >> 1));
    gate_n  = (state_n == ST_HOP_RX);
    hrst_n  = (state_n == ST_HOP_SYNC) && (k_n < sh_hop_settle);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      k_q      <= '0;
      idx_q    <= '0;
      rx_valid <= 1'b0;
      rx_gate  <= 1'b0;
      hop_rst  <= 1'b0;
      done     <= 1'b0;
      err_cfg  <= 1'b0;
    end else begin
      state_q  <= state_n;
      k_q      <= k_n;
      idx_q    <= idx_n;
      rx_valid <= valid_n;
      rx_gate  <= gate_n;
      hop_rst  <= hrst_n;
      done     <= done_n;
      err_cfg  <= err_cfg | err_set;
    end
  end

  always_ff @(posedge clk) begin
    if (latch) begin
      sh_nhops      <= cfg_nhops;
      sh_nsync_loc  <= cfg_nsync_loc;
      sh_nsync_hop  <= cfg_nsync_hop;
      sh_hop_settle <= cfg_hop_settle;
      sh_nsig       <= cfg_nsig;
      sh_continuous <= cfg_continuous;
    end
  end

  // Sample stage: one register between RX input and DSP output.
  always_ff @(posedge clk) begin
    if (reset) begin
      irx_out  <= '0;
      qrx_out  <= '0;
      hop_code <= '0;
    end else begin
      if (valid_n) begin
        irx_out <= neg_n ? AMP_N : AMP_P;
        qrx_out <= '0;
      end else begin
        irx_out <= irx_in;
        qrx_out <= qrx_in;
      end
      if (state_q == ST_HOP_SYNC && k_q == '0) hop_code <= tbl_rdata;
    end
  end

  assign hop_idx = idx_q;
  assign state   = state_q;

endmodule

// File: doc/tag_rx_hop_seq.md
# tag_rx_hop_seq

Parametrised tag receive sequencer: on an external sync trigger it injects a localisation preamble into the RX IQ stream, then steps through a runtime-programmable list of frequency hops. For each hop it presents the hop's IF code to the scan serializer under a reset/settle window, then gates a fixed-length receive interval. It sits between the radio RX IQ path and the DSP chain.

## Interface
- DATA_WIDTH, 16: IQ sample width
- CODE_WIDTH, 32: hop IF code width
- MAX_HOPS, 64: hop table depth
- IDX_WIDTH, 6: log2(MAX_HOPS)
- CNT_WIDTH, 24: width of all interval counters/config lengths
- SYNC_AMP, 28672: preamble amplitude, must fit DATA_WIDTH signed
- clk in 1: clock clk
- reset in 1: reset, synchronous, active-high
- cfg_nhops in IDX_WIDTH+1: hops per sweep, 1..MAX_HOPS
- cfg_nsync_loc in CNT_WIDTH: preamble length L, ≥4
- cfg_nsync_hop in CNT_WIDTH: hop settle interval length S
- cfg_hop_settle in CNT_WIDTH: hop_rst width H, 2 ≤ H < S
- cfg_nsig in CNT_WIDTH: receive interval length N, ≥1
- cfg_continuous in 1: restart the sweep after the last hop
- tbl_we in 1, tbl_addr in IDX_WIDTH, tbl_wdata in CODE_WIDTH: hop table write port
- trigger in 1: sync request, already synchronised, level
- abort in 1: return to IDLE
- irx_in, qrx_in in DATA_WIDTH: RX samples
- irx_out, qrx_out out DATA_WIDTH: registered sample output
- rx_valid out 1: preamble valid window
- rx_gate out 1: receive interval active
- hop_rst out 1: scan serializer reset
- hop_idx out IDX_WIDTH: current hop index
- hop_code out CODE_WIDTH: current hop IF code
- state out 2: IDLE=0, LOC_SYNC=1, HOP_SYNC=2, HOP_RX=3
- done out 1: one-cycle sweep-complete pulse
- err_cfg out 1: sticky invalid-config flag, cleared only by reset

## Operation
- Reset: state IDLE; all outputs 0; counters 0. The table contents are not reset.
- IDLE: on trigger, check the config.
  - If invalid (any range above violated): set err_cfg and remain in IDLE.
  - If valid: latch all cfg_* into shadow registers, set k=0, hop_idx=0, and go to LOC_SYNC.
  - cfg_* changes have no effect until the next latch.
- LOC_SYNC, L cycles, k=0..L-1:
  - rx_valid=1 for k ≥ L>>2.
  - While rx_valid=1, irx_out = −SYNC_AMP for k < L>>1, else +SYNC_AMP; qrx_out=0.
  - Otherwise irx_out/qrx_out pass through the inputs.
  - After k=L-1, go to HOP_SYNC.
- HOP_SYNC, S cycles, k=0..S-1:
  - hop_rst=1 for k < H.
  - hop_code is loaded from table[hop_idx] and is valid from k=1.
  - After k=S-1, go to HOP_RX.
- HOP_RX, N cycles:
  - rx_gate=1; samples pass through.
  - After the last cycle:
    - If hop_idx < nhops-1: increment hop_idx and go to HOP_SYNC.
    - Otherwise pulse done and set hop_idx=0; then go to LOC_SYNC if the shadow continuous bit is set, else IDLE.
- trigger is ignored outside IDLE.
- abort has priority over everything except reset. On the next cycle: state=IDLE, rx_valid/rx_gate/hop_rst=0, no done pulse.
- Table writes are accepted in any state. hop_code is registered, so a write to the active index takes effect only at that index's next HOP_SYNC load.
- Counters compare against latched values; there is no wrap. CNT_WIDTH bounds all lengths.

## Timing
- irx_out/qrx_out, rx_valid, rx_gate, hop_rst, state and done are all registered.
- Sample path latency is 1 cycle: input at cycle t appears at t+1, aligned with rx_valid/rx_gate for that cycle.
- trigger high at edge t gives state=LOC_SYNC at t+1.
- Table read is synchronous with 1-cycle latency. The address is presented in the cycle that enters HOP_SYNC.
- A sweep takes L + nhops·(S+N) cycles from LOC_SYNC entry to done.

## Structure
- Shared package tag_pkg holds:
  - the state encoding constants;
  - the default SYNC_AMP;
  - the IQ and code width defaults, shared with the scan serializer and GPIO controller.
- Sub-module hop_code_table: simple dual-port RAM, MAX_HOPS×CODE_WIDTH, synchronous read, one write port. No reset on the storage.

## Test plan
- Write codes 0x11,0x22,0x33; nhops=3, L=16, S=8, H=3, N=10; pulse trigger.
  - rx_valid asserts for 12 cycles: 4 at −28672, then 8 at +28672.
  - hop_code takes 0x11, 0x22, 0x33 in turn.
  - hop_rst is 3 cycles per hop; rx_gate is 10 cycles per hop.
  - done pulses once after 70 cycles; state returns to IDLE.
- Same config with cfg_continuous=1: done pulses every 70 cycles and the LOC_SYNC preamble repeats.
- cfg_nhops=0, or H=S=8: trigger sets err_cfg and state stays 0.
- Assert abort in HOP_RX of hop 1: state=0 next cycle, outputs zero, no done pulse. A fresh trigger restarts from hop 0.
- Write table[1]=0x99 during hop 1 RX: the current hop_code stays 0x22. In the next continuous sweep, hop 1 shows 0x99.
- Raise trigger again during HOP_SYNC: no effect. Assert reset mid-LOC_SYNC: all outputs 0 on the next cycle.
